// File: rtl/bl_wl_config_pkg.sv
`default_nettype none
//==============================================================================
// Module      : bl_wl_config_pkg
// Description : Shared state encoding and CRC-16-CCITT helpers for the bl/wl
//               configuration writer.
// Revision    : 1.0 - initial release
//==============================================================================
package bl_wl_config_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5,
        ST_CHECK = 3'd6,
        ST_ERR   = 3'd7
    } state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // One serial bit of CRC-16-CCITT, message MSB first.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic data_bit);
        logic feedback;
        feedback = crc[15] ^ data_bit;
        return {crc[14:0], 1'b0} ^ (feedback ? CRC_POLY : 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bl_wl_pulse_timer.sv
`default_nettype none
//==============================================================================
// Module      : bl_wl_pulse_timer
// Description : Loadable down-counter timing the SETUP/PULSE/HOLD phases;
//               expired is high during the final cycle of the loaded duration.
// Revision    : 1.0 - initial release
//==============================================================================
module bl_wl_pulse_timer #(
    parameter int WIDTH = 1
) (
    input  logic             prog_clk,
    input  logic             global_resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;
    logic             r_active;

    // A load on the expiry cycle starts the next phase without a gap.
    always_ff @(posedge prog_clk or negedge global_resetn) begin
        if (!global_resetn) begin
            r_count  <= '0;
            r_active <= 1'b0;
        end else if (load) begin
            r_count  <= load_value;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_count == '0) begin
                r_active <= 1'b0;
            end else begin
                r_count <= r_count - WIDTH'(1);
            end
        end
    end

    assign expired = r_active && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/bl_wl_config_writer.sv
`default_nettype none
//==============================================================================
// Module      : bl_wl_config_writer
// Description : Serial bitstream to memory-bank bl/wl writer. Assembles one
//               NUM_BL-bit frame per row and commits it with a one-hot wl pulse.
// Options     : BL_WL_CONFIG_WRITER_CRC_EN adds a CRC-16 trailer check
//               (CHECK/ERR states, sticky error output).
// Revision    : 1.0 - initial release
//==============================================================================
module bl_wl_config_writer
    import bl_wl_config_pkg::*;
#(
    parameter int NUM_BL   = 70,
    parameter int NUM_WL   = 70,
    parameter int WL_SETUP = 1,
    parameter int WL_PULSE = 2,
    parameter int WL_HOLD  = 1
) (
    input  logic              prog_clk,
    input  logic              global_resetn,
    input  logic              start,
    input  logic              cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [NUM_BL-1:0] bl,
    output logic [NUM_WL-1:0] wl,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int BIT_W   = (NUM_BL > 1) ? $clog2(NUM_BL) : 1;
    localparam int ROW_W   = (NUM_WL > 1) ? $clog2(NUM_WL) : 1;
    localparam int TMR_MX1 = (WL_SETUP > WL_PULSE) ? WL_SETUP : WL_PULSE;
    localparam int TMR_MAX = (TMR_MX1 > WL_HOLD) ? TMR_MX1 : WL_HOLD;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    state_t              r_state;
    logic [BIT_W-1:0]    r_bit;
    logic [ROW_W-1:0]    r_row;
    logic [NUM_BL-1:0]   r_bl;
    logic [NUM_WL-1:0]   r_wl;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;

    logic                w_xfer;
    logic                w_last_bit;
    logic                w_last_row;
    logic                w_start_ok;
    logic                w_tmr_load;
    logic [TMR_W-1:0]    w_tmr_value;
    logic                w_tmr_expired;

`ifdef BL_WL_CONFIG_WRITER_CRC_EN
    logic [15:0]         r_crc;
    logic [15:0]         r_trailer;
    logic [3:0]          r_trl_cnt;
    logic                r_error;
    logic [15:0]         w_trailer_next;

    assign w_trailer_next = {r_trailer[14:0], cfg_data};
`endif

    assign w_xfer     = cfg_valid && r_ready;
    assign w_last_bit = (r_bit == BIT_W'(NUM_BL - 1));
    assign w_last_row = (r_row == ROW_W'(NUM_WL - 1));
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                  (r_state == ST_ERR));

    // Timer loads on the same edge the FSM enters the phase it times.
    always_comb begin
        w_tmr_load  = 1'b0;
        w_tmr_value = '0;
        case (r_state)
            ST_SHIFT: begin
                if (w_xfer && w_last_bit) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_value = TMR_W'(WL_SETUP - 1);
                end
            end
            ST_SETUP: begin
                if (w_tmr_expired) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_value = TMR_W'(WL_PULSE - 1);
                end
            end
            ST_PULSE: begin
                if (w_tmr_expired) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_value = TMR_W'(WL_HOLD - 1);
                end
            end
            default: begin
                w_tmr_load  = 1'b0;
                w_tmr_value = '0;
            end
        endcase
    end

    bl_wl_pulse_timer #(
        .WIDTH         (TMR_W)
    ) u_pulse_timer (
        .prog_clk      (prog_clk),
        .global_resetn (global_resetn),
        .load          (w_tmr_load),
        .load_value    (w_tmr_value),
        .expired       (w_tmr_expired)
    );

    always_ff @(posedge prog_clk or negedge global_resetn) begin
        if (!global_resetn) begin
            r_state   <= ST_IDLE;
            r_bit     <= '0;
            r_row     <= '0;
            r_bl      <= '0;
            r_wl      <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef BL_WL_CONFIG_WRITER_CRC_EN
            r_crc     <= CRC_INIT;
            r_trailer <= '0;
            r_trl_cnt <= '0;
            r_error   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (w_start_ok) begin
                        r_state   <= ST_SHIFT;
                        r_row     <= '0;
                        r_bit     <= '0;
                        r_ready   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
`ifdef BL_WL_CONFIG_WRITER_CRC_EN
                        r_crc     <= CRC_INIT;
                        r_error   <= 1'b0;
`endif
                    end
                end

                ST_SHIFT: begin
                    if (w_xfer) begin
                        r_bl[r_bit] <= cfg_data;
`ifdef BL_WL_CONFIG_WRITER_CRC_EN
                        r_crc       <= crc16_step(r_crc, cfg_data);
`endif
                        if (w_last_bit) begin
                            r_bit   <= '0;
                            r_ready <= 1'b0;
                            r_state <= ST_SETUP;
                        end else begin
                            r_bit   <= r_bit + BIT_W'(1);
                        end
                    end
                end

                ST_SETUP: begin
                    if (w_tmr_expired) begin
                        r_wl    <= NUM_WL'(1) << r_row;
                        r_state <= ST_PULSE;
                    end
                end

                ST_PULSE: begin
                    if (w_tmr_expired) begin
                        r_wl    <= '0;
                        r_state <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    if (w_tmr_expired) begin
                        if (w_last_row) begin
`ifdef BL_WL_CONFIG_WRITER_CRC_EN
                            r_state   <= ST_CHECK;
                            r_ready   <= 1'b1;
                            r_trl_cnt <= '0;
`else
                            r_state   <= ST_DONE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
`endif
                        end else begin
                            r_row   <= r_row + ROW_W'(1);
                            r_ready <= 1'b1;
                            r_state <= ST_SHIFT;
                        end
                    end
                end

`ifdef BL_WL_CONFIG_WRITER_CRC_EN
                // Trailer arrives MSB first; compare on the 16th bit.
                ST_CHECK: begin
                    if (w_xfer) begin
                        r_trailer <= w_trailer_next;
                        r_trl_cnt <= r_trl_cnt + 4'd1;
                        if (r_trl_cnt == 4'd15) begin
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                            if (w_trailer_next == r_crc) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_ERR;
                                r_error <= 1'b1;
                            end
                        end
                    end
                end
`endif

                default: begin
                    r_state <= ST_IDLE;
                    r_wl    <= '0;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = r_ready;
    assign bl        = r_bl;
    assign wl        = r_wl;
    assign busy      = r_busy;
    assign done      = r_done;

`ifdef BL_WL_CONFIG_WRITER_CRC_EN
    assign error     = r_error;
`else
    assign error     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bl_wl_config_writer.sv
`default_nettype none
//==============================================================================
// Module      : tb_bl_wl_config_writer
// Description : Randomised scoreboard bench for bl_wl_config_writer; a monitor
//               checks every wl pulse, done/error event and bus invariant.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_bl_wl_config_writer;

    localparam int NUM_BL   = 4;
    localparam int NUM_WL   = 70;
    localparam int WL_SETUP = 1;
    localparam int WL_PULSE = 2;
    localparam int WL_HOLD  = 1;

    localparam int K_COMMIT = 0;
    localparam int K_DONE   = 1;
    localparam int K_ERR    = 2;

    typedef struct {
        int                kind;
        int                row;
        logic [NUM_BL-1:0] frame;
    } exp_t;

    logic              prog_clk      = 1'b0;
    logic              global_resetn = 1'b0;
    logic              start         = 1'b0;
    logic              cfg_data      = 1'b0;
    logic              cfg_valid     = 1'b0;
    logic              cfg_ready;
    logic [NUM_BL-1:0] bl;
    logic [NUM_WL-1:0] wl;
    logic              busy;
    logic              done;
    logic              error;

    int   total    = 0;
    int   bad      = 0;
    int   n_pulses = 0;
    exp_t sb_q[$];

    always #5 prog_clk = ~prog_clk;

    bl_wl_config_writer #(
        .NUM_BL        (NUM_BL),
        .NUM_WL        (NUM_WL),
        .WL_SETUP      (WL_SETUP),
        .WL_PULSE      (WL_PULSE),
        .WL_HOLD       (WL_HOLD)
    ) dut (
        .prog_clk      (prog_clk),
        .global_resetn (global_resetn),
        .start         (start),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .bl            (bl),
        .wl            (wl),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference CRC-16-CCITT over one message bit, MSB-first convention.
    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic b);
        logic [15:0] sh;
        sh = c << 1;
        return (c[15] ^ b) ? (sh ^ 16'h1021) : sh;
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [NUM_BL-1:0] prev_bl;
        logic [NUM_WL-1:0] prev_wl;
        logic [NUM_WL-1:0] one;
        logic              prev_done;
        logic              prev_err;
        logic              prev_xfer;
        int                cyc;
        int                bitcnt;
        int                last_cyc;
        int                plen;
        exp_t              e;
        prev_bl = '0; prev_wl = '0; prev_done = 1'b0; prev_err = 1'b0; prev_xfer = 1'b0;
        cyc = 0; bitcnt = 0; last_cyc = 0; plen = 0; one = 1;
        forever begin
            @(negedge prog_clk);
            cyc++;
            if (!global_resetn) begin
                prev_bl = '0; prev_wl = '0; prev_done = 1'b0; prev_err = 1'b0;
                prev_xfer = 1'b0; bitcnt = 0; plen = 0;
            end else begin
                check("wl_onehot0", 128'($onehot0(wl)), 128'(1));
                if (bl !== prev_bl) check("bl_change_needs_transfer", 128'(prev_xfer), 128'(1));
                if (prev_wl == '0 && wl != '0) begin
                    plen = 1;
                    n_pulses++;
                    check("sb_has_commit", 128'(sb_q.size() > 0), 128'(1));
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check("sb_kind_commit", 128'(e.kind), 128'(K_COMMIT));
                        check("wl_row", 128'(wl), 128'(one << e.row));
                        check("bl_frame", 128'(bl), 128'(e.frame));
                        check("wl_latency", 128'(cyc - last_cyc), 128'(WL_SETUP + 1));
                    end
                end else if (prev_wl != '0 && wl != '0) begin
                    plen++;
                    check("wl_steady", 128'(wl), 128'(prev_wl));
                end else if (prev_wl != '0 && wl == '0) begin
                    check("wl_pulse_len", 128'(plen), 128'(WL_PULSE));
                end
                if (done && !prev_done) begin
                    check("sb_has_done", 128'(sb_q.size() > 0), 128'(1));
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check("sb_kind_done", 128'(e.kind), 128'(K_DONE));
                    end
                end
                if (error && !prev_err) begin
                    check("sb_has_err", 128'(sb_q.size() > 0), 128'(1));
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check("sb_kind_err", 128'(e.kind), 128'(K_ERR));
                    end
                end
                if (start && !busy) bitcnt = 0;
                if (cfg_valid && cfg_ready) begin
                    bitcnt++;
                    if (bitcnt == NUM_BL) begin
                        bitcnt   = 0;
                        last_cyc = cyc;
                    end
                end
                prev_bl   = bl;
                prev_wl   = wl;
                prev_done = done;
                prev_err  = error;
                prev_xfer = cfg_valid && cfg_ready;
            end
        end
    end

    // ---------------- stimulus helpers (aligned to posedge + 1) ----------------
    task automatic idle(input int n);
        cfg_valid = 1'b0;
        repeat (n) @(posedge prog_clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge prog_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        logic accepted;
        int   guard;
        cfg_data  = b;
        cfg_valid = 1'b1;
        accepted  = 1'b0;
        guard     = 0;
        while (!accepted && guard < 200) begin
            @(negedge prog_clk);
            accepted = cfg_ready;
            @(posedge prog_clk);
            #1;
            guard++;
        end
        cfg_valid = 1'b0;
        check("send_bit_accepted", 128'(accepted), 128'(1));
    endtask

    task automatic stall_check(input int n);
        logic [NUM_BL-1:0] snap;
        cfg_valid = 1'b0;
        snap = bl;
        repeat (n) begin
            @(negedge prog_clk);
            check("stall_wl_zero", 128'(wl), 128'(0));
            check("stall_bl_stable", 128'(bl), 128'(snap));
            @(posedge prog_clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [NUM_BL-1:0] f0, input logic [NUM_BL-1:0] f1,
                           input int stall_at, input bit rnd_stall, input bit glitch,
                           input bit bad_crc);
        logic [NUM_BL-1:0] fr;
        logic [NUM_BL-1:0] last_fr;
        logic [15:0]       crc;
        logic [15:0]       trailer;
        int                base;
        int                guard;
        base    = n_pulses;
        crc     = 16'hFFFF;
        last_fr = '0;
        trailer = '0;
        pulse_start();
        check("start_busy", 128'(busy), 128'(1));
        check("start_clears_done", 128'(done), 128'(0));
        check("start_clears_error", 128'(error), 128'(0));
        for (int r = 0; r < NUM_WL; r++) begin
            fr = (r == 0) ? f0 : (r == 1) ? f1 : NUM_BL'($urandom);
            sb_q.push_back('{kind: K_COMMIT, row: r, frame: fr});
            for (int b = 0; b < NUM_BL; b++) begin
                if (r == 0 && b == stall_at) stall_check(5);
                else if (rnd_stall && $urandom_range(0, 7) == 0) idle($urandom_range(1, 4));
                send_bit(fr[b]);
                crc = crc_model(crc, fr[b]);
                if (glitch && r == 1 && b == 0) begin
                    pulse_start();
                    check("ignored_start_busy", 128'(busy), 128'(1));
                end
            end
            last_fr = fr;
        end
`ifdef BL_WL_CONFIG_WRITER_CRC_EN
        trailer = crc;
        if (bad_crc) trailer[$urandom_range(0, 15)] ^= 1'b1;
        for (int i = 15; i >= 0; i--) send_bit(trailer[i]);
        sb_q.push_back('{kind: (bad_crc ? K_ERR : K_DONE), row: 0, frame: '0});
`else
        sb_q.push_back('{kind: K_DONE, row: 0, frame: '0});
`endif
        guard = 0;
        while (!(done || error) && guard < 200) begin
            @(negedge prog_clk);
            guard++;
        end
        check("load_finished", 128'(done || error), 128'(1));
        check("done_flag", 128'(done), 128'(!bad_crc));
        check("error_flag", 128'(error), 128'(bad_crc));
        check("end_busy", 128'(busy), 128'(0));
        check("end_ready", 128'(cfg_ready), 128'(0));
        check("end_wl", 128'(wl), 128'(0));
        check("end_bl", 128'(bl), 128'(last_fr));
        check("pulse_count", 128'(n_pulses - base), 128'(NUM_WL));
        @(posedge prog_clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_bl"}, 128'(bl), 128'(0));
        check({tag, "_wl"}, 128'(wl), 128'(0));
        check({tag, "_ready"}, 128'(cfg_ready), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_done"}, 128'(done), 128'(0));
        check({tag, "_error"}, 128'(error), 128'(0));
    endtask

    task automatic reset_mid_pulse();
        logic [NUM_BL-1:0] fr;
        int                guard;
        fr = NUM_BL'($urandom);
        pulse_start();
        sb_q.push_back('{kind: K_COMMIT, row: 0, frame: fr});
        for (int b = 0; b < NUM_BL; b++) send_bit(fr[b]);
        guard = 0;
        while (wl == '0 && guard < 50) begin
            @(negedge prog_clk);
            guard++;
        end
        check("rst_pulse_cycle1", 128'(wl), 128'(1));
        @(posedge prog_clk);
        #1;
        check("rst_pulse_cycle2", 128'(wl), 128'(1));
        global_resetn = 1'b0;
        #1;
        check_reset_values("midpulse_rst");
        repeat (3) @(posedge prog_clk);
        #1;
        global_resetn = 1'b1;
        @(posedge prog_clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin : stim
        repeat (3) @(posedge prog_clk);
        #1;
        check_reset_values("por");
        global_resetn = 1'b1;
        @(posedge prog_clk);
        #1;

        do_load(4'b1101, 4'b0110, -1, 1'b0, 1'b0, 1'b0);
        do_load(4'b1101, 4'b0110, 2, 1'b0, 1'b0, 1'b0);
        reset_mid_pulse();
        do_load(NUM_BL'($urandom), NUM_BL'($urandom), -1, 1'b1, 1'b0, 1'b0);
        do_load(NUM_BL'($urandom), NUM_BL'($urandom), -1, 1'b1, 1'b1, 1'b0);
`ifdef BL_WL_CONFIG_WRITER_CRC_EN
        do_load(NUM_BL'($urandom), NUM_BL'($urandom), -1, 1'b1, 1'b0, 1'b1);
        idle(10);
        check("err_sticky_error", 128'(error), 128'(1));
        check("err_sticky_done", 128'(done), 128'(0));
        check("err_sticky_busy", 128'(busy), 128'(0));
        do_load(NUM_BL'($urandom), NUM_BL'($urandom), -1, 1'b0, 1'b0, 1'b0);
`endif
        idle(5);
        check("sb_drained", 128'(sb_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/bl_wl_config_writer.md
Name: bl_wl_config_writer

Overview:
- Configuration-side master for the flattened memory-bank SRAM in the logical tiles: the writer end of the bl/wl interface that tile memories (e.g. mux_tree_size2_mem, LUT/ff_bypass SRAM) receive.
- Accepts a serial bitstream over a valid/ready handshake, assembles one frame of NUM_BL bits, then asserts exactly one wordline to commit it.
- Sits between the bitstream loader and the tile/grid bl/wl buses.

Parameters:
- NUM_BL, 70, bitline count (frame width, bits per row).
- NUM_WL, 70, wordline count (rows).
- WL_SETUP, 1, cycles BL held stable before WL rises (>=1).
- WL_PULSE, 2, cycles WL held high (>=1).
- WL_HOLD, 1, cycles BL held stable after WL falls (>=1).

Ports:
- prog_clk  in  1  configuration clock; all state on rising edge.
- global_resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load at row 0; ignored unless IDLE or DONE.
- cfg_data  in  1  bitstream bit; bit 0 of each frame arrives first.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  writer accepts the bit this cycle (transfer = valid & ready).
- bl  out  NUM_BL  bitline bus, index 0 = first bit received.
- wl  out  NUM_WL  wordline bus, one-hot or zero.
- busy  out  1  high in any state except IDLE/DONE/ERR.
- done  out  1  high in DONE until the next start.
- error  out  1  sticky error (CRC build only), cleared by start or reset.

Behaviour:
- Reset (async, active-low): state IDLE; bl=0, wl=0, cfg_ready=0, busy=0, done=0, error=0; bit and row counters=0.
- States: IDLE, SHIFT, SETUP, PULSE, HOLD, DONE (plus CHECK and ERR with the optional feature).
- IDLE/DONE + start: go to SHIFT; row=0, bit=0, done=0, error=0.
- SHIFT: cfg_ready=1.
  - Each transfer writes bl[bit]=cfg_data and increments bit.
  - On the transfer with bit==NUM_BL-1: bit=0, go to SETUP; cfg_ready is 0 from the next cycle.
- SETUP: wl=0, bl stable for WL_SETUP cycles, then go to PULSE.
- PULSE: wl[row]=1 and all other bits 0 for exactly WL_PULSE cycles, then go to HOLD.
- HOLD: wl=0, bl unchanged for WL_HOLD cycles.
  - If row==NUM_WL-1: go to DONE (or CHECK with the optional feature).
  - Otherwise row+1 and go to SHIFT.
- Latency from the last bit of a frame to wl rising: WL_SETUP+1 cycles.
- bl changes only in SHIFT. wl is never high outside PULSE and never has more than one bit set.
- DONE: done=1, busy=0, bl keeps the last frame, wl=0.
- start while busy: ignored.
- cfg_valid low in SHIFT: stall with no timeout.
- Reset mid-pulse: wl clears asynchronously and immediately.
- Counter widths: $clog2 of each limit, minimum 1 bit. Row increments without wrap; the terminal compare takes precedence.

Optional Feature:
- Macro: BL_WL_CONFIG_WRITER_CRC_EN.
- Defined:
  - A CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first over the serial bits) runs across every data bit of the load.
  - After the last row's HOLD, state CHECK accepts 16 further trailer bits (cfg_ready=1) as the expected CRC, received MSB first.
  - Match: go to DONE. Mismatch: go to ERR with error=1, done=0, busy=0. ERR leaves only on start or reset.
- Not defined: no CHECK/ERR states, error is tied to 0, HOLD of the last row goes directly to DONE.

Decomposition:
- Package bl_wl_config_pkg holds:
  - the state enum;
  - CRC_POLY=16'h1021 and CRC_INIT=16'hFFFF;
  - the function crc16_step(crc, bit).
- One sub-module is natural: bl_wl_pulse_timer, a loadable down-counter that sequences SETUP/PULSE/HOLD durations and emits an expiry strobe.

Test Plan:
- NUM_BL=4, NUM_WL=2, defaults; start, stream 1,0,1,1 then 0,1,1,0 with valid held high -> bl=4'b1101 (bl[0]=1) with wl=2'b01 for 2 cycles, then bl=4'b0110 with wl=2'b10 for 2 cycles, then done=1.
- Same stream with cfg_valid low for 5 cycles mid-frame -> bl stable and wl=0 throughout the stall; final bl/wl sequence identical to the first test.
- Reset asserted on the 2nd PULSE cycle of row 0 -> wl=0 in the same cycle, all outputs at reset values; a fresh start reloads from row 0.
- start pulsed during SHIFT of row 1 -> ignored; row 1 completes on the original data.
- Monitor over a NUM_WL=70 full load -> exactly 70 wl pulses, each one-hot and in ascending index order, $onehot0(wl) on every cycle, bl never changing while any wl bit is high.
- CRC build: correct 16-bit trailer -> done=1, error=0. Trailer with one bit flipped -> error=1, done=0, state ERR until the next start.
